// File: rtl/ascii_num_pkg.sv
// Shared definitions for the ASCII decimal tokenizer: byte codes, the parser
// state encoding, byte classification and the signed 32-bit magnitude limits.
package ascii_num_pkg;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SEMI  = 8'h3B;

    // Largest positive int32 magnitude and magnitude of the most negative int32
    localparam logic [31:0] INT32_POS_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_NEG_MAG = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NEG  = 3'd1,
        S_NUM  = 3'd2,
        S_SKIP = 3'd3,
        S_DONE = 3'd4
    } tok_state_t;

    typedef enum logic [2:0] {
        C_DIGIT   = 3'd0,
        C_MINUS   = 3'd1,
        C_SEP     = 3'd2,
        C_TERM    = 3'd3,
        C_ILLEGAL = 3'd4
    } tok_class_t;

    // Map an input byte onto the small set of classes the parser reacts to
    function automatic tok_class_t classify(input logic [7:0] b);
        tok_class_t c;
        if ((b >= CH_ZERO) && (b <= CH_NINE)) begin
            c = C_DIGIT;
        end else if (b == CH_MINUS) begin
            c = C_MINUS;
        end else if ((b == CH_SPACE) || (b == CH_COMMA) || (b == CH_TAB) || (b == CH_CR)) begin
            c = C_SEP;
        end else if ((b == CH_LF) || (b == CH_SEMI)) begin
            c = C_TERM;
        end else begin
            c = C_ILLEGAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// Combinational decimal step: next_acc = acc*10 + digit.
// With ASCII_TOKEN_OVERFLOW_DETECT_EN defined the result saturates at the
// int32 magnitude limit for the token's sign and flags overflow; otherwise the
// magnitude wraps modulo 2^32 and overflow is always 0.
module decimal_accumulator
    import ascii_num_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [3:0]  digit,
    input  logic        neg,
    output logic [31:0] next_acc,
    output logic        overflow
);

    logic [35:0] acc_w_s;
    logic [35:0] prod_s;

    // Widen so the x10 product of any in-range magnitude is exact
    assign acc_w_s = {4'd0, acc};
    assign prod_s  = (acc_w_s << 3) + (acc_w_s << 1) + {32'd0, digit};

`ifdef ASCII_TOKEN_OVERFLOW_DETECT_EN
    logic [35:0] limit_s;

    assign limit_s = neg ? {4'd0, INT32_NEG_MAG} : {4'd0, INT32_POS_MAX};

    // Clamp to the sign-dependent limit; once clamped, further digits keep it there
    always_comb begin
        if (prod_s > limit_s) begin
            next_acc = limit_s[31:0];
            overflow = 1'b1;
        end else begin
            next_acc = prod_s[31:0];
            overflow = 1'b0;
        end
    end
`else
    logic unused_s;

    assign unused_s = ^{neg, prod_s[35:32]};

    // Plain modulo-2^32 accumulation
    always_comb begin
        next_acc = prod_s[31:0];
        overflow = 1'b0;
    end
`endif

endmodule

// File: rtl/ascii_int_tokenizer.sv
// ASCII decimal integer tokenizer feeding the RAM write controller.
// Parses whitespace/comma separated signed integers terminated by LF or ';',
// emitting one registered data_valid pulse per token, a running token count
// and a parse_done level. The frame is re-armed with a clear pulse in S_DONE.
// MAX_TOKENS must not exceed 2**COUNT_W - 1.
// Optional: ASCII_TOKEN_OVERFLOW_DETECT_EN enables magnitude saturation and
// the sticky err_overflow flag (tied 0 when undefined).
module ascii_int_tokenizer
    import ascii_num_pkg::*;
#(
    parameter int COUNT_W    = 11,
    parameter int MAX_TOKENS = 2047
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               clear,
    output logic [31:0]        data_out,
    output logic               data_valid,
    output logic [COUNT_W-1:0] total_count,
    output logic               parse_done,
    output logic               err_format,
    output logic               err_overflow
);

    tok_state_t  state_r;
    tok_state_t  state_next_s;
    tok_class_t  class_s;
    logic        accept_s;
    logic [3:0]  digit_s;
    logic [31:0] acc_r;
    logic        neg_r;
    logic [31:0] acc_next_s;
    logic        acc_ovf_s;
    logic [31:0] emit_value_s;
    logic        cap_hit_s;

    // Control decode outputs
    logic        acc_load_s;
    logic        acc_neg_s;
    logic        acc_step_s;
    logic        emit_s;
    logic        err_fmt_set_s;
    logic        ovf_set_s;
    logic        clear_frame_s;

    assign accept_s     = rx_valid && rx_ready;
    assign class_s      = classify(rx_data);
    assign digit_s      = rx_data[3:0];
    assign cap_hit_s    = (total_count == COUNT_W'(MAX_TOKENS));
    assign emit_value_s = neg_r ? (32'd0 - acc_r) : acc_r;

    decimal_accumulator u_acc (
        .acc      (acc_r),
        .digit    (digit_s),
        .neg      (neg_r),
        .next_acc (acc_next_s),
        .overflow (acc_ovf_s)
    );

    // Parser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state selection from current state and accepted byte class
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    case (class_s)
                        C_DIGIT: state_next_s = S_NUM;
                        C_MINUS: state_next_s = S_NEG;
                        C_SEP:   state_next_s = S_IDLE;
                        C_TERM:  state_next_s = S_DONE;
                        default: state_next_s = S_SKIP;
                    endcase
                end else begin
                    state_next_s = state_r;
                end
            end
            S_NEG, S_NUM: begin
                if (accept_s) begin
                    case (class_s)
                        C_DIGIT: state_next_s = S_NUM;
                        C_SEP:   state_next_s = S_IDLE;
                        C_TERM:  state_next_s = S_DONE;
                        default: state_next_s = S_SKIP;
                    endcase
                end else begin
                    state_next_s = state_r;
                end
            end
            S_SKIP: begin
                if (accept_s) begin
                    case (class_s)
                        C_SEP:   state_next_s = S_IDLE;
                        C_TERM:  state_next_s = S_DONE;
                        default: state_next_s = S_SKIP;
                    endcase
                end else begin
                    state_next_s = state_r;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Datapath control decode: accumulator moves, token emission, error raising
    always_comb begin
        acc_load_s    = 1'b0;
        acc_neg_s     = 1'b0;
        acc_step_s    = 1'b0;
        emit_s        = 1'b0;
        err_fmt_set_s = 1'b0;
        ovf_set_s     = 1'b0;
        clear_frame_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    case (class_s)
                        C_DIGIT:   acc_load_s    = 1'b1;
                        C_ILLEGAL: err_fmt_set_s = 1'b1;
                        default:   acc_load_s    = 1'b0;
                    endcase
                end else begin
                    acc_load_s = 1'b0;
                end
            end
            S_NEG: begin
                if (accept_s) begin
                    case (class_s)
                        C_DIGIT: begin
                            acc_load_s = 1'b1;
                            acc_neg_s  = 1'b1;
                        end
                        default: err_fmt_set_s = 1'b1;
                    endcase
                end else begin
                    acc_load_s = 1'b0;
                end
            end
            S_NUM: begin
                if (accept_s) begin
                    case (class_s)
                        C_DIGIT: begin
                            acc_step_s = 1'b1;
                            ovf_set_s  = acc_ovf_s;
                        end
                        C_SEP, C_TERM: begin
                            if (cap_hit_s) begin
                                err_fmt_set_s = 1'b1;
                            end else begin
                                emit_s = 1'b1;
                            end
                        end
                        default: err_fmt_set_s = 1'b1;
                    endcase
                end else begin
                    acc_step_s = 1'b0;
                end
            end
            S_DONE: begin
                if (clear) begin
                    clear_frame_s = 1'b1;
                end else begin
                    clear_frame_s = 1'b0;
                end
            end
            default: clear_frame_s = 1'b0;
        endcase
    end

    // Registered handshake and frame-status levels derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready   <= 1'b1;
            parse_done <= 1'b0;
        end else begin
            rx_ready   <= (state_next_s != S_DONE);
            parse_done <= (state_next_s == S_DONE);
        end
    end

    // Magnitude accumulator and sign of the token in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 32'd0;
            neg_r <= 1'b0;
        end else if (clear_frame_s) begin
            acc_r <= 32'd0;
            neg_r <= 1'b0;
        end else if (acc_load_s) begin
            acc_r <= {28'd0, digit_s};
            neg_r <= acc_neg_s;
        end else if (acc_step_s) begin
            acc_r <= acc_next_s;
        end
    end

    // Token output register: one-cycle valid pulse, value held between tokens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= 32'd0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= emit_s;
            if (emit_s) begin
                data_out <= emit_value_s;
            end
        end
    end

    // Per-frame token counter, stepped together with data_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_count <= '0;
        end else if (clear_frame_s) begin
            total_count <= '0;
        end else if (emit_s) begin
            total_count <= total_count + COUNT_W'(1);
        end
    end

    // Sticky malformed-token flag, cleared only when a new frame starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_format <= 1'b0;
        end else if (clear_frame_s) begin
            err_format <= 1'b0;
        end else if (err_fmt_set_s) begin
            err_format <= 1'b1;
        end
    end

`ifdef ASCII_TOKEN_OVERFLOW_DETECT_EN
    // Sticky magnitude-overflow flag, cleared only when a new frame starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
        end else if (clear_frame_s) begin
            err_overflow <= 1'b0;
        end else if (ovf_set_s) begin
            err_overflow <= 1'b1;
        end
    end
`else
    logic unused_ovf_s;

    assign unused_ovf_s = acc_ovf_s ^ ovf_set_s;
    assign err_overflow = 1'b0;
`endif

endmodule

// File: doc/ascii_int_tokenizer.md
Name: ascii_int_tokenizer

Overview:
- Upstream stage of the RAM write controller in the ascii_num_sep path.
- Consumes a byte stream of ASCII decimal integers separated by whitespace or commas, ending with a terminator.
- Emits one signed 32-bit value per token as a single-cycle valid pulse, plus a final token count and a parse_done level.
- Outputs connect directly to the write controller's data_in/data_valid/total_count/parse_done.

Parameters:
- COUNT_W, 11: width of total_count.
- MAX_TOKENS, 2047: maximum tokens emitted per frame. Must be ≤ 2^COUNT_W−1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  ASCII byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- clear  in  1  pulse: leave DONE, start a new frame
- data_out  out  32  signed token value
- data_valid  out  1  one-cycle pulse per emitted token
- total_count  out  COUNT_W  tokens emitted this frame
- parse_done  out  1  level: frame terminated
- err_format  out  1  sticky: malformed token seen
- err_overflow  out  1  sticky: magnitude overflow (macro only, else tied 0)

Behaviour:
- Reset: data_out=0, data_valid=0, total_count=0, parse_done=0, err_*=0, accumulator=0, state=S_IDLE.
- This is clocked asynchronous active-low reset; reset mid-frame discards the partial token and the count.
- rx_ready=1 in every state except S_DONE.
- Byte classes:
  - digit: 0x30–0x39
  - minus: 0x2D
  - separator: 0x20, 0x2C, 0x09, 0x0D
  - terminator: 0x0A, 0x3B
  - anything else is illegal.
- States:
  - S_IDLE: separator→stay; digit→S_NUM (acc=digit, neg=0); minus→S_NEG; terminator→S_DONE; illegal→S_SKIP, set err_format.
  - S_NEG: digit→S_NUM (acc=digit, neg=1); separator→S_IDLE + err_format (lone '-'); terminator→S_DONE + err_format; minus/illegal→S_SKIP + err_format.
  - S_NUM: digit→acc=acc*10+digit; separator→emit, S_IDLE; terminator→emit, S_DONE; minus/illegal→S_SKIP + err_format, no emit.
  - S_SKIP: separator→S_IDLE; terminator→S_DONE; others ignored.
  - S_DONE: parse_done=1; stays until clear. On clear: total_count=0, err flags cleared, →S_IDLE.
- Arithmetic:
  - acc is 32-bit unsigned magnitude; acc*10 is computed as (acc<<3)+(acc<<1).
  - Emit value = neg ? −acc : acc, truncated to 32 bits. Leading zeros are allowed; "-0" emits 0.
- Latency:
  - data_valid and data_out register one cycle after the delimiter byte is accepted.
  - total_count increments in that same cycle.
  - parse_done rises one cycle after the terminator is accepted, coinciding with the final data_valid if one is emitted.
- Count cap: when total_count==MAX_TOKENS, further tokens are not emitted, total_count holds, and err_format is set.
- clear outside S_DONE: ignored.
- clear concurrent with rx_valid: clear wins (rx_ready is already 0 in S_DONE).
- Empty frame (terminator only): parse_done with total_count=0.

Optional Feature:
- Macro: ASCII_TOKEN_OVERFLOW_DETECT_EN.
- Defined:
  - Per-digit check that magnitude stays ≤ 2147483647 (neg=0) or ≤ 2147483648 (neg=1).
  - On exceed, acc saturates at the limit, further digits are ignored, and err_overflow is set (sticky until clear/reset).
  - Emitted values are 0x7FFFFFFF or 0x80000000.
- Undefined:
  - acc wraps modulo 2^32 and emits the wrapped two's-complement value.
  - err_overflow is tied 0.

Decomposition:
- Package ascii_num_pkg:
  - byte constants (CH_ZERO, CH_NINE, CH_MINUS, CH_SPACE, CH_COMMA, CH_TAB, CH_CR, CH_LF, CH_SEMI)
  - state enum tok_state_t
  - INT32_POS_MAX and INT32_NEG_MAG constants
- Sub-module decimal_accumulator: combinational next_acc = acc*10+digit, plus the overflow/saturation logic under the macro. The FSM and registers stay in the top.

Test Plan:
- "12,-34 5\n" → data_valid pulses with 12, −34, 5; total_count=3; parse_done=1; err_format=0.
- "\n" only → no data_valid; parse_done=1; total_count=0. Then clear → parse_done=0, rx_ready=1, next frame "7;" emits 7.
- "1a2 - 9\n" → err_format=1; "1a2" and "-" not emitted; only 9 emitted; total_count=1.
- "2147483647 -2147483648\n" → emits 0x7FFFFFFF and 0x80000000 in both builds.
- "4294967296\n":
  - with ASCII_TOKEN_OVERFLOW_DETECT_EN → emits 0x7FFFFFFF, err_overflow=1.
  - without → emits 0.
- rst_n asserted after "12" mid-token, then released with "3\n" → emits 3 only; total_count=1. Also: random rx_valid gaps do not change the emitted values.
